// File: rtl/memory_game_pkg.sv
// Shared types and defaults for the memory-card turn sequencer.
//   state_t         : turn sequencer states
//   NUM_CARDS_DEF   : default board size
//   SHOW_CYCLES_DEF : default face-up time for a mismatched pair
//   timer_width()   : counter width able to hold SHOW_CYCLES-1 (never below 1)
package memory_game_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FIRST   = 3'd1,
        SECOND  = 3'd2,
        COMPARE = 3'd3,
        SHOW    = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int NUM_CARDS_DEF   = 16;
    localparam int SHOW_CYCLES_DEF = 50_000_000;

    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/show_timer.sv
// Loadable down-counter that holds a mismatched pair face-up.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : load val_i (has priority over en_i)
//   val_i      : value to load
//   en_i       : count down by one; the counter stops at zero
//   zero_o     : counter is zero
module show_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    // Count register: load wins, otherwise decrement until zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/memory_game_ctrl.sv
// Turn sequencer for the memory-card game: accepts two selections per turn,
// compares their pair IDs, retires matches and turns mismatches back down
// after SHOW_CYCLES cycles.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : clear the board and begin a game (from any state)
//   map_we/addr/pair      : card-to-pair map write, honoured only in IDLE
//   sel_valid, sel_pos    : selection request; sel_ready says it was taken
//   flipped/matched_mask  : face-up cards / retired cards
//   unselect_all          : pulse when a mismatched pair is turned down
//   match_pulse           : pulse when a pair is retired
//   pairs_left, move_count: progress counters; game_over in DONE
module memory_game_ctrl
    import memory_game_pkg::*;
#(
    parameter int NUM_CARDS   = NUM_CARDS_DEF,
    parameter int POS_W       = $clog2(NUM_CARDS),
    parameter int PAIR_W      = $clog2(NUM_CARDS / 2),
    parameter int SHOW_CYCLES = SHOW_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 map_we,
    input  logic [POS_W-1:0]     map_addr,
    input  logic [PAIR_W-1:0]    map_pair,
    input  logic                 sel_valid,
    input  logic [POS_W-1:0]     sel_pos,
    output logic                 sel_ready,
    output logic [NUM_CARDS-1:0] flipped_mask,
    output logic [NUM_CARDS-1:0] matched_mask,
    output logic                 unselect_all,
    output logic                 match_pulse,
    output logic [PAIR_W:0]      pairs_left,
    output logic [15:0]          move_count,
    output logic                 game_over
);

    localparam int               TMR_W      = timer_width(SHOW_CYCLES);
    localparam logic [PAIR_W:0]  PAIRS_INIT = (PAIR_W+1)'(NUM_CARDS / 2);
    localparam logic [PAIR_W:0]  ONE_PAIR   = (PAIR_W+1)'(1);
    localparam logic [POS_W:0]   POS_LIMIT  = (POS_W+1)'(NUM_CARDS);
    localparam logic [TMR_W-1:0] SHOW_LOAD  = TMR_W'(SHOW_CYCLES - 1);

    state_t               state_q, state_d;
    logic [NUM_CARDS-1:0] flipped_q, flipped_d;
    logic [NUM_CARDS-1:0] matched_q, matched_d;
    logic [POS_W-1:0]     pos_a_q, pos_a_d;
    logic [POS_W-1:0]     pos_b_q, pos_b_d;
    logic [PAIR_W:0]      pairs_q, pairs_d;
    logic [15:0]          moves_q, moves_d;
    logic                 match_q, match_d;
    logic                 unsel_q, unsel_d;
    logic                 over_q;

    logic [PAIR_W-1:0]    map_q [NUM_CARDS];

    logic                 accept_s;
    logic                 pair_eq_s;
    logic                 tmr_load_s;
    logic [TMR_W-1:0]     tmr_val_s;
    logic                 tmr_en_s;
    logic                 tmr_zero_s;

    // Selection is accepted only while waiting for a card that is on the board and face-down.
    assign sel_ready = ((state_q == FIRST) || (state_q == SECOND))
                     && ({1'b0, sel_pos} < POS_LIMIT)
                     && !flipped_q[sel_pos];
    assign accept_s  = sel_valid && sel_ready;
    assign pair_eq_s = (map_q[pos_a_q] == map_q[pos_b_q]);

    show_timer #(.W(TMR_W)) u_show_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tmr_load_s),
        .val_i  (tmr_val_s),
        .en_i   (tmr_en_s),
        .zero_o (tmr_zero_s)
    );

    // Card-to-pair map; writable only while idle, start takes precedence.
    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && map_we && !start && ({1'b0, map_addr} < POS_LIMIT)) begin
            map_q[map_addr] <= map_pair;
        end
    end

    // Next-state and next-output logic; start overrides every other event.
    always_comb begin
        state_d    = state_q;
        flipped_d  = flipped_q;
        matched_d  = matched_q;
        pos_a_d    = pos_a_q;
        pos_b_d    = pos_b_q;
        pairs_d    = pairs_q;
        moves_d    = moves_q;
        match_d    = 1'b0;
        unsel_d    = 1'b0;
        tmr_load_s = 1'b0;
        tmr_val_s  = '0;
        tmr_en_s   = 1'b0;
        if (start) begin
            state_d    = FIRST;
            flipped_d  = '0;
            matched_d  = '0;
            pairs_d    = PAIRS_INIT;
            moves_d    = 16'd0;
            tmr_load_s = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                FIRST: begin
                    if (accept_s) begin
                        flipped_d[sel_pos] = 1'b1;
                        pos_a_d            = sel_pos;
                        state_d            = SECOND;
                    end else begin
                        state_d = FIRST;
                    end
                end
                SECOND: begin
                    if (accept_s) begin
                        flipped_d[sel_pos] = 1'b1;
                        pos_b_d            = sel_pos;
                        state_d            = COMPARE;
                    end else begin
                        state_d = SECOND;
                    end
                end
                COMPARE: begin
                    moves_d = (moves_q == 16'hFFFF) ? moves_q : moves_q + 16'd1;
                    if (pair_eq_s) begin
                        matched_d[pos_a_q] = 1'b1;
                        matched_d[pos_b_q] = 1'b1;
                        match_d            = 1'b1;
                        pairs_d            = pairs_q - ONE_PAIR;
                        state_d            = (pairs_q == ONE_PAIR) ? DONE : FIRST;
                    end else begin
                        tmr_load_s = 1'b1;
                        tmr_val_s  = SHOW_LOAD;
                        state_d    = SHOW;
                    end
                end
                SHOW: begin
                    if (tmr_zero_s) begin
                        flipped_d[pos_a_q] = 1'b0;
                        flipped_d[pos_b_q] = 1'b0;
                        unsel_d            = 1'b1;
                        state_d            = FIRST;
                    end else begin
                        tmr_en_s = 1'b1;
                        state_d  = SHOW;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            flipped_q <= '0;
            matched_q <= '0;
            pos_a_q   <= '0;
            pos_b_q   <= '0;
            pairs_q   <= PAIRS_INIT;
            moves_q   <= 16'd0;
            match_q   <= 1'b0;
            unsel_q   <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            flipped_q <= flipped_d;
            matched_q <= matched_d;
            pos_a_q   <= pos_a_d;
            pos_b_q   <= pos_b_d;
            pairs_q   <= pairs_d;
            moves_q   <= moves_d;
            match_q   <= match_d;
            unsel_q   <= unsel_d;
            over_q    <= (state_d == DONE);
        end
    end

    assign flipped_mask = flipped_q;
    assign matched_mask = matched_q;
    assign pairs_left   = pairs_q;
    assign move_count   = moves_q;
    assign match_pulse  = match_q;
    assign unselect_all = unsel_q;
    assign game_over    = over_q;

endmodule
